// File: rtl/router_out_sched.sv
// router_out_sched: read-side scheduler for the 1x3 router.
// One shared downstream sink drains three output FIFOs. A requesting FIFO is
// picked round-robin and owns the grant for one whole packet. The packet is
// {len[5:0],addr[1:0]} header, len payload bytes, then one parity byte.
//
// Ports
//   clock               in   system clock, rising edge
//   resetn              in   synchronous active-low reset
//   vld_out_0..2        in   FIFO N non-empty
//   data_out_0..2 [7:0] in   FIFO N read data, valid the cycle after read_enb_N
//   dst_ready           in   sink can take one more byte; gates read issue
//   read_enb_0..2       out  FIFO N read strobe (combinational)
//   sink_data [7:0]     out  byte from the granted FIFO (0 when not valid)
//   sink_valid          out  sink_data valid this cycle
//   sink_sop/sink_eop   out  header / parity byte markers, with sink_valid
//   sink_abort          out  one-cycle pulse: current packet abandoned
//   grant [1:0]         out  FIFO index currently owned
//   sched_busy          out  scheduler not idle
//
// state | meaning
// IDLE  | no owner; pick next requester from rr_ptr
// HDR   | read header byte from granted FIFO
// LEN   | header on sink; load payload+parity byte count
// BODY  | read payload and parity bytes
// LAST  | parity byte on sink; advance rr_ptr
module router_out_sched #(
  parameter int unsigned STALL_MAX = 32
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out_0,
  input  logic       vld_out_1,
  input  logic       vld_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  input  logic       dst_ready,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [7:0] sink_data,
  output logic       sink_valid,
  output logic       sink_sop,
  output logic       sink_eop,
  output logic       sink_abort,
  output logic [1:0] grant,
  output logic       sched_busy
);

  localparam int unsigned SW = $clog2(STALL_MAX);
  localparam logic [SW-1:0] STALL_TC = SW'(STALL_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LEN  = 3'd2,
    S_BODY = 3'd3,
    S_LAST = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]    grant_q, grant_d;
  logic [6:0]    count_q, count_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          rd_q;

  logic [2:0] req;
  logic       vld_g;
  logic [7:0] data_g;
  logic [1:0] scan1, scan2, pick;
  logic       active, fire, starve, abort;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign req = {vld_out_2, vld_out_1, vld_out_0};

  always_comb begin
    vld_g  = 1'b0;
    data_g = 8'h00;
    case (grant_q)
      2'd0:    begin vld_g = vld_out_0; data_g = data_out_0; end
      2'd1:    begin vld_g = vld_out_1; data_g = data_out_1; end
      2'd2:    begin vld_g = vld_out_2; data_g = data_out_2; end
      default: ;
    endcase
  end

  assign scan1 = next_port(rr_ptr_q);
  assign scan2 = next_port(scan1);
  assign pick  = req[rr_ptr_q] ? rr_ptr_q : (req[scan1] ? scan1 : scan2);

  assign active = (state_q == S_HDR) || (state_q == S_BODY);
  assign fire   = active && vld_g && dst_ready;
  // dst_ready low freezes the watchdog: only a starved source counts.
  assign starve = active && !vld_g && dst_ready;
  assign abort  = starve && (stall_q == STALL_TC);

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rr_ptr_q <= 2'd0;
      grant_q  <= 2'd0;
      count_q  <= 7'd0;
      stall_q  <= '0;
      rd_q     <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
      rd_q     <= fire;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    count_d  = count_q;
    stall_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (req != 3'b000) begin
          grant_d = pick;
          state_d = S_HDR;
        end
      end
      S_HDR, S_BODY: begin
        if (fire) begin
          if (state_q == S_HDR) begin
            state_d = S_LEN;
          end else begin
            count_d = count_q - 7'd1;
            if (count_q == 7'd1) state_d = S_LAST;
          end
        end else if (abort) begin
          rr_ptr_d = next_port(grant_q);
          state_d  = S_IDLE;
        end else if (starve) begin
          stall_d = stall_q + 1'b1;
        end else begin
          stall_d = stall_q;
        end
      end
      S_LEN: begin
        // header is on data_out now; count covers payload plus parity
        count_d = {1'b0, data_g[7:2]} + 7'd1;
        state_d = S_BODY;
      end
      S_LAST: begin
        rr_ptr_d = next_port(grant_q);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    read_enb_0 = fire && (grant_q == 2'd0);
    read_enb_1 = fire && (grant_q == 2'd1);
    read_enb_2 = fire && (grant_q == 2'd2);
    sink_valid = rd_q;
    sink_data  = rd_q ? data_g : 8'h00;
    sink_sop   = (state_q == S_LEN);
    sink_eop   = (state_q == S_LAST);
    sink_abort = abort;
    grant      = grant_q;
    sched_busy = (state_q != S_IDLE);
  end

endmodule
